// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: shift ops, FSM states
// and default operand sizing.
package shift_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_AMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_one_step.sv
// Combinational single-position shifter shared by every shift operation;
// the sequencer applies it once per cycle to build a shift by N.
module shift_one_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Arbitrates two shift requesters onto one single-bit shift step and iterates
// it N times; res_data doubles as the working register while shifting.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amount,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amount,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);

    state_t           state;
    logic [AMT_W-1:0] count;
    logic             last_grant;
    logic [1:0]       op_reg;
    logic             grant;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic [AMT_W-1:0] sel_amount;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] step_q;

    // Round-robin only matters on contention; a lone requester always wins.
    always_comb begin
        grant = ~last_grant;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        sel_valid  = req0_valid;
        sel_data   = req0_data;
        sel_amount = req0_amount;
        sel_op     = req0_op;
        if (grant) begin
            sel_valid  = req1_valid;
            sel_data   = req1_data;
            sel_amount = req1_amount;
            sel_op     = req1_op;
        end
    end

    assign req0_ready = (state == ST_IDLE) && !grant;
    assign req1_ready = (state == ST_IDLE) && grant;
    assign busy       = (state != ST_IDLE);

    shift_one_step #(.WIDTH(WIDTH)) u_step (
        .d  (res_data),
        .op (op_reg),
        .q  (step_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            count      <= '0;
            last_grant <= 1'b1;
            op_reg     <= OP_SLL;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        res_id     <= grant;
                        last_grant <= grant;
                        op_reg     <= sel_op;
                        res_data   <= sel_data;
                        if (sel_amount == '0) begin
                            res_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            count <= sel_amount;
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    res_data <= step_q;
                    count    <= count - 1'b1;
                    if (count == AMT_W'(1)) begin
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic
// shift/arbitration reference model.
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_amount, req1_amount;
    logic [1:0]  req0_op, req1_op;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_id;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;
    int last_id    = 1;

    shift_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_amount (req0_amount),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_amount (req1_amount),
        .req1_op     (req1_op),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_id      (res_id),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference shift by n computed directly with operators, not step by step.
    function automatic logic [31:0] refShift(input logic [1:0] op, input logic [31:0] d, input int n);
        logic [31:0] r;
        case (op)
            2'b00:   r = d << n;
            2'b01:   r = d >> n;
            2'b10:   r = $signed(d) >>> n;
            default: r = (n == 0) ? d : ((d << n) | (d >> (32 - n)));
        endcase
        return r;
    endfunction

    task automatic doReset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        last_id = 1;
        @(negedge clock);
    endtask

    // One full transaction from the current negedge in IDLE through handshake.
    task automatic applyStimulus(input logic v0, input logic v1,
                                 input logic [1:0] op0, input logic [31:0] d0, input logic [4:0] a0,
                                 input logic [1:0] op1, input logic [31:0] d1, input logic [4:0] a1,
                                 input int hold);
        int          exp_id;
        int          exp_amt;
        int          n;
        logic [31:0] exp_data;
        exp_id   = (v0 && v1) ? (1 - last_id) : (v1 ? 1 : 0);
        exp_amt  = (exp_id == 1) ? int'(a1) : int'(a0);
        exp_data = (exp_id == 1) ? refShift(op1, d1, int'(a1)) : refShift(op0, d0, int'(a0));
        req0_valid = v0; req0_op = op0; req0_data = d0; req0_amount = a0;
        req1_valid = v1; req1_op = op1; req1_data = d1; req1_amount = a1;
        res_ready = 1'b0;
        #1;
        checkOutput("req0_ready_idle", 32'(req0_ready), 32'(exp_id == 0));
        checkOutput("req1_ready_idle", 32'(req1_ready), 32'(exp_id == 1));
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        last_id = exp_id;
        n = 1;
        while (!res_valid && n < 80) begin
            @(negedge clock);
            n++;
        end
        checkOutput("latency", 32'(n), 32'(exp_amt + 1));
        checkOutput("res_data", res_data, exp_data);
        checkOutput("res_id", 32'(res_id), 32'(exp_id));
        checkOutput("busy_done", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            req0_valid = 1'b1; req0_data = $urandom; req0_amount = 5'($urandom);
            req1_valid = 1'b1; req1_data = $urandom; req1_amount = 5'($urandom);
            @(negedge clock);
            checkOutput("hold_valid", 32'(res_valid), 32'd1);
            checkOutput("hold_data", res_data, exp_data);
            checkOutput("hold_id", 32'(res_id), 32'(exp_id));
            checkOutput("hold_ready0", 32'(req0_ready), 32'd0);
            checkOutput("hold_ready1", 32'(req1_ready), 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        checkOutput("valid_after_hs", 32'(res_valid), 32'd0);
        checkOutput("busy_after_hs", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        v0, v1;
        logic [31:0] d0, d1;
        int          got;
        int          exp_id;
        int          n;
        reset_n = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_amount = '0; req0_op = '0;
        req1_valid = 1'b0; req1_data = '0; req1_amount = '0; req1_op = '0;
        res_ready = 1'b0;
        doReset();
        checkOutput("rst_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_data", res_data, 32'd0);
        checkOutput("rst_id", 32'(res_id), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // Directed cases
        applyStimulus(1, 0, 2'b00, 32'h0000_0004, 5'd1, 2'b00, 32'h0, 5'd0, 0);
        checkOutput("sll_literal", res_data, 32'h0000_0008);
        applyStimulus(0, 1, 2'b00, 32'h0, 5'd0, 2'b10, 32'h8000_0000, 5'd31, 0);
        checkOutput("sra_literal", res_data, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 2'b01, 32'h1234_5678, 5'd0, 2'b00, 32'h0, 5'd0, 0);
        checkOutput("amt0_literal", res_data, 32'h1234_5678);
        applyStimulus(1, 0, 2'b11, 32'h8000_0001, 5'd4, 2'b00, 32'h0, 5'd0, 5);
        checkOutput("rol_literal", res_data, 32'h0000_0018);

        // Continuous contention from reset: grants must alternate starting at 0
        doReset();
        d0 = $urandom; d1 = $urandom;
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = d0; req0_amount = 5'd1;
        req1_valid = 1'b1; req1_op = 2'b11; req1_data = d1; req1_amount = 5'd1;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = 1 - last_id;
            n = 0;
            @(negedge clock);
            while (!res_valid && n < 20) begin
                @(negedge clock);
                n++;
            end
            checkOutput("rr_id", 32'(res_id), 32'(exp_id));
            checkOutput("rr_data", res_data, (exp_id == 1) ? refShift(2'b11, d1, 1) : refShift(2'b00, d0, 1));
            last_id = exp_id;
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        @(negedge clock);
        res_ready = 1'b0;

        // Asynchronous reset in the middle of a long shift
        req0_valid = 1'b1; req0_op = 2'b01; req0_data = $urandom; req0_amount = 5'd20;
        @(negedge clock);
        req0_valid = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("busy_pre_reset", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(res_valid), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_data", res_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        last_id = 1;
        @(negedge clock);
        applyStimulus(1, 1, 2'b10, 32'hF000_0000, 5'd3, 2'b00, 32'h1, 5'd3, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            got = $urandom_range(1, 3);
            v0 = got[0];
            v1 = got[1];
            applyStimulus(v0, v1,
                          2'($urandom), $urandom, 5'($urandom),
                          2'($urandom), $urandom, 5'($urandom),
                          $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
